// File: rtl/fb_burst_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : fb_burst_writer
//  Purpose  : Avalon-MM burst write master for the HPS FPGA-to-SDRAM write
//             port. Buffers a 64-bit pixel word stream in a small FIFO and
//             writes it to a linear framebuffer region as fixed-length bursts.
//             A burst is only committed once every one of its beats is already
//             buffered, so avm_write never drops in the middle of a burst.
//
//  Ports    :
//    clk              system clock
//    reset            asynchronous active-high reset
//    start            one-cycle transfer start pulse (ignored while busy)
//    base_addr        first word address, sampled on start
//    word_count       number of 64-bit words, sampled on start
//    in_data/in_valid/in_ready
//                     input word stream (accepted on in_valid && in_ready)
//    busy             transfer in progress
//    done             one-cycle completion pulse
//    avm_address      burst start word address
//    avm_burstcount   beats in the current burst
//    avm_writedata    beat data (FIFO head)
//    avm_byteenable   all ones while avm_write, otherwise zero
//    avm_write        write request
//    avm_waitrequest  slave stall
//
//  Revision : 1.0  initial release
// ============================================================================
module fb_burst_writer #(
  parameter int ADDR_W     = 29,
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 22
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  word_count,
  input  logic [63:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic [7:0]        avm_burstcount,
  output logic [63:0]       avm_writedata,
  output logic [7:0]        avm_byteenable,
  output logic              avm_write,
  input  logic              avm_waitrequest
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Common width for comparing FIFO occupancy against an 8-bit burst length.
  localparam int CMP_W = (CNT_W > 8) ? CNT_W : 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // --------------------------------------------------------------------------
  // Control registers
  // --------------------------------------------------------------------------
  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;
  logic [LEN_W-1:0]  in_left_q,   in_left_d;
  logic [LEN_W-1:0]  out_left_q,  out_left_d;
  logic [7:0]        beats_q,     beats_d;
  logic [ADDR_W-1:0] addr_q,      addr_d;
  logic [7:0]        bcount_q,    bcount_d;
  logic              write_q,     write_d;

  // --------------------------------------------------------------------------
  // FIFO storage
  // --------------------------------------------------------------------------
  logic [63:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q,  count_d;

  logic       fifo_full;
  logic       push;
  logic       pop;
  logic [7:0] blen;
  logic       fill_ready;

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign in_ready  = (state_q != ST_IDLE) && !fifo_full && (in_left_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = write_q && !avm_waitrequest;
  assign count_d   = count_q + CNT_W'(push) - CNT_W'(pop);

  // Length of the next burst: a full burst, or whatever remains.
  assign blen = (out_left_q >= LEN_W'(BURST_LEN)) ? 8'(BURST_LEN) : 8'(out_left_q);

  // Looking at the post-push occupancy lets the burst be committed on the same
  // edge that buffers its last word, so avm_write rises the very next cycle.
  assign fill_ready = (CMP_W'(count_d) >= CMP_W'(blen));

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign busy           = (state_q == ST_FILL) || (state_q == ST_BURST);
  assign done           = (state_q == ST_DONE);
  assign avm_address    = addr_q;
  assign avm_burstcount = bcount_q;
  assign avm_write      = write_q;
  assign avm_byteenable = write_q ? 8'hFF : 8'h00;
  // Show-ahead head of the FIFO; masked so the bus is quiet between bursts.
  assign avm_writedata  = write_q ? mem_q[rd_ptr_q] : 64'd0;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    in_left_d   = in_left_q;
    out_left_d  = out_left_q;
    beats_d     = beats_q;
    addr_d      = addr_q;
    bcount_d    = bcount_q;
    write_d     = write_q;

    if (push) begin
      in_left_d = in_left_q - LEN_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          next_addr_d = base_addr;
          in_left_d   = word_count;
          out_left_d  = word_count;
          state_d     = (word_count == '0) ? ST_DONE : ST_FILL;
        end
      end

      ST_FILL: begin
        if (fill_ready) begin
          addr_d   = next_addr_q;
          bcount_d = blen;
          beats_d  = blen;
          write_d  = 1'b1;
          state_d  = ST_BURST;
        end
      end

      ST_BURST: begin
        if (pop) begin
          out_left_d = out_left_q - LEN_W'(1);
          beats_d    = beats_q - 8'd1;
          if (beats_q == 8'd1) begin
            write_d     = 1'b0;
            next_addr_d = next_addr_q + ADDR_W'(bcount_q);
            state_d     = (out_left_q == LEN_W'(1)) ? ST_DONE : ST_FILL;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      next_addr_q <= '0;
      in_left_q   <= '0;
      out_left_q  <= '0;
      beats_q     <= '0;
      addr_q      <= '0;
      bcount_q    <= '0;
      write_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      in_left_q   <= in_left_d;
      out_left_q  <= out_left_d;
      beats_q     <= beats_d;
      addr_q      <= addr_d;
      bcount_q    <= bcount_d;
      write_q     <= write_d;
    end
  end

  // FIFO pointers and occupancy; reset discards any buffered words.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
    end
  end

  // Storage array has no reset; stale contents are never visible because the
  // read side only presents data while a committed burst is active.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fb_burst_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_fb_burst_writer
//  Purpose  : Self-checking bench for fb_burst_writer. A table of transfer
//             scenarios is run with randomized handshakes; a transaction-level
//             model (queue of accepted words, burst index arithmetic) supplies
//             every expected value.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fb_burst_writer;

  localparam int ADDR_W     = 29;
  localparam int BURST_LEN  = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int LEN_W      = 22;
  localparam int CYC_LIMIT  = 2000;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  word_count;
  logic [63:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] avm_address;
  logic [7:0]        avm_burstcount;
  logic [63:0]       avm_writedata;
  logic [7:0]        avm_byteenable;
  logic              avm_write;
  logic              avm_waitrequest;

  always #5 clk = ~clk;

  fb_burst_writer #(
    .ADDR_W     (ADDR_W),
    .BURST_LEN  (BURST_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .LEN_W      (LEN_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .word_count      (word_count),
    .in_data         (in_data),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .busy            (busy),
    .done            (done),
    .avm_address     (avm_address),
    .avm_burstcount  (avm_burstcount),
    .avm_writedata   (avm_writedata),
    .avm_byteenable  (avm_byteenable),
    .avm_write       (avm_write),
    .avm_waitrequest (avm_waitrequest)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " avm_write"},      64'(avm_write),      64'd0);
    chk({tag, " avm_address"},    64'(avm_address),    64'd0);
    chk({tag, " avm_burstcount"}, 64'(avm_burstcount), 64'd0);
    chk({tag, " avm_writedata"},  avm_writedata,       64'd0);
    chk({tag, " avm_byteenable"}, 64'(avm_byteenable), 64'd0);
    chk({tag, " busy"},           64'(busy),           64'd0);
    chk({tag, " done"},           64'(done),           64'd0);
    chk({tag, " in_ready"},       64'(in_ready),       64'd0);
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    int count;
    int wait_pct;      // chance of waitrequest per cycle
    int valid_pct;     // chance of in_valid per cycle
    int hold_until;    // waitrequest forced high before this cycle
    int gap_after;     // after this many accepted words, in_valid low 20 cycles
    int restart_at;    // cycle at which a stray start is pulsed
    int abort_at;      // cycle at which reset is asserted
    int exp_bursts;
    int exp_last_bc;
    int exp_first_wr;  // cycle of first avm_write (-1: not checked)
    int exp_max_occ;   // peak FIFO occupancy (-1: not checked)
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0]       words[$];
    logic [ADDR_W-1:0] exp_addr;
    int  acc, written, bursts, in_burst, last_bc, occ, max_occ;
    int  cycle, first_wr, gap_left, blen, rem;
    bit  done_next, prev_final, finished, aborted, exp_rdy;

    acc = 0; written = 0; bursts = 0; in_burst = 0; last_bc = 0;
    max_occ = 0; first_wr = -1; gap_left = 20;
    done_next = (v.count == 0); prev_final = 1'b0;
    finished = 1'b0; aborted = 1'b0;

    @(negedge clk);
    start           = 1'b1;
    base_addr       = v.base;
    word_count      = LEN_W'(v.count);
    in_valid        = 1'b0;
    avm_waitrequest = 1'b0;
    cycle           = 0;

    while (!finished) begin
      @(negedge clk);
      cycle++;
      start = 1'b0;

      // ---- compare outputs against the transaction model ----
      occ     = acc - written;
      if (occ > max_occ) max_occ = occ;
      exp_rdy = !done_next && (acc < v.count) && (occ < FIFO_DEPTH);
      rem     = v.count - bursts * BURST_LEN;
      blen    = (rem > BURST_LEN) ? BURST_LEN : rem;
      exp_addr = v.base + ADDR_W'(bursts * BURST_LEN);

      chk("busy",       64'(busy),     64'(!done_next));
      chk("done",       64'(done),     64'(done_next));
      chk("in_ready",   64'(in_ready), 64'(exp_rdy));
      chk("byteenable", 64'(avm_byteenable), avm_write ? 64'hFF : 64'h0);

      if (avm_write) begin
        chk("beat_within_count", 64'(written < v.count), 64'd1);
        if (written < v.count) begin
          if (in_burst == 0) begin
            chk("commit_fully_buffered", 64'(occ >= blen), 64'd1);
            if (first_wr < 0) first_wr = cycle;
          end
          chk("address",    64'(avm_address),    64'(exp_addr));
          chk("burstcount", 64'(avm_burstcount), 64'(blen));
          chk("writedata",  avm_writedata,       words[written]);
        end
      end else if (in_burst != 0) begin
        chk("write_held_mid_burst", 64'(avm_write), 64'd1);
      end
      if (prev_final) begin
        chk("idle_cycle_between_bursts", 64'(avm_write), 64'd0);
      end

      if (cycle == v.abort_at) begin
        // Reset lands mid-cycle while a beat is presented.
        #2 reset = 1'b1;
        #1 chk_all_zero("reset_mid_burst");
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        avm_waitrequest = 1'b0;
        #1 chk_all_zero("after_reset_release");
        aborted  = 1'b1;
        finished = 1'b1;
      end else if (done_next) begin
        finished = 1'b1;
      end else begin
        // ---- drive the next cycle ----
        if (v.gap_after >= 0 && acc == v.gap_after && gap_left > 0) begin
          in_valid = 1'b0;
          gap_left--;
        end else begin
          in_valid = ($urandom_range(99) < 32'(v.valid_pct));
        end
        in_data = {$urandom, 32'(acc)};
        avm_waitrequest = (cycle < v.hold_until) ? 1'b1 :
                          ($urandom_range(99) < 32'(v.wait_pct));
        if (cycle == v.restart_at) begin
          start      = 1'b1;
          base_addr  = ~v.base;
          word_count = LEN_W'(5);
        end

        // ---- advance the model over the coming edge ----
        if (in_valid && exp_rdy) begin
          words.push_back(in_data);
          acc++;
        end
        prev_final = 1'b0;
        if (avm_write && !avm_waitrequest && written < v.count) begin
          written++;
          in_burst++;
          if (in_burst == blen) begin
            bursts++;
            in_burst   = 0;
            last_bc    = blen;
            prev_final = 1'b1;
            if (written == v.count) done_next = 1'b1;
          end
        end

        if (cycle >= CYC_LIMIT) begin
          checks++;
          errors++;
          $display("FAIL timeout vec %0d: actual=%0d beats required=%0d beats", idx, written, v.count);
          reset = 1'b1;
          @(negedge clk);
          reset = 1'b0;
          aborted  = 1'b1;
          finished = 1'b1;
        end
      end
    end

    if (!aborted) begin
      chk($sformatf("vec%0d bursts", idx),  64'(bursts),  64'(v.exp_bursts));
      chk($sformatf("vec%0d last_bc", idx), 64'(last_bc), 64'(v.exp_last_bc));
      chk($sformatf("vec%0d beats", idx),   64'(written), 64'(v.count));
      if (v.exp_first_wr >= 0)
        chk($sformatf("vec%0d first_write_cycle", idx), 64'(first_wr), 64'(v.exp_first_wr));
      if (v.exp_max_occ >= 0)
        chk($sformatf("vec%0d max_fifo_occupancy", idx), 64'(max_occ), 64'(v.exp_max_occ));
      @(negedge clk);
      chk("done_single_pulse", 64'(done), 64'd0);
      chk("idle_after_done",   64'(busy | avm_write | in_ready), 64'd0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //          base          cnt wt% vl% hold gap rst abrt brs lbc 1stw occ
    vecs[0]  = '{29'h100,      16,  0, 100,  0, -1, -1, -1,  2,  8,  9, -1};
    vecs[1]  = '{29'h2000,     11,  0, 100,  0, -1, -1, -1,  2,  3,  9, -1};
    vecs[2]  = '{29'h5000,     40, 50,  80,  0, -1, -1, -1,  5,  8, -1, -1};
    vecs[3]  = '{29'h800,      16,  0, 100,  0,  5, -1, -1,  2,  8, 29, -1};
    vecs[4]  = '{29'h900,      32,  0, 100, 40, -1, -1, -1,  4,  8,  9, 16};
    vecs[5]  = '{29'h10,        0,  0, 100,  0, -1, -1, -1,  0,  0, -1, -1};
    vecs[6]  = '{29'h3000,     12, 30,  70,  0, -1,  3, -1,  2,  4, -1, -1};
    vecs[7]  = '{29'h1FFFFFFC, 20, 25,  90,  0, -1, -1, -1,  3,  4, -1, -1};
    vecs[8]  = '{29'h7,         1,  0, 100,  0, -1, -1, -1,  1,  1,  2, -1};
    vecs[9]  = '{29'h400,      16,  0, 100,  0, -1, -1, 10,  0,  0, -1, -1};
    vecs[10] = '{29'h600,       8,  0, 100,  0, -1, -1, -1,  1,  8,  9, -1};
    vecs[11] = '{29'hA0,       37, 40,  50,  0, -1, -1, -1,  5,  5, -1, -1};

    reset           = 1'b1;
    start           = 1'b0;
    base_addr       = '0;
    word_count      = '0;
    in_data         = '0;
    in_valid        = 1'b0;
    avm_waitrequest = 1'b0;

    #1 chk_all_zero("reset_state");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_all_zero("idle_after_reset");

    for (int i = 0; i < 12; i++) begin
      run_vec(i, vecs[i]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
